load_store_multi: RTL and testbench



---
 rtl/load_store_pkg.sv | 23 ++
 rtl/load_store_channel.sv | 108 ++++++++++
 rtl/load_store_multi.sv | 52 +++++
 tb/tb_load_store_multi.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_pkg.sv
// Shared types and saturating helpers for the load/store ramp channels.
// Helpers work in a 32-bit domain with a carry bit, so callers never see wrap-around.
package load_store_pkg;

  typedef enum logic [1:0] {RISE = 2'd0, HOLD = 2'd1, FALL = 2'd2} state_e;
  typedef enum logic {MODE_TRI = 1'b0, MODE_SAW = 1'b1} mode_e;

  localparam int AW = 32;

  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] lim);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] sat_sub(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/load_store_channel.sv
// One ramp channel: limit/mode config, RISE/HOLD/FALL FSM, dwell counter.
// All outputs registered, updated on the same edge as state; no backpressure (en only freezes).
module load_store_channel
  import load_store_pkg::*;
#(
  parameter int CBITS = 18,
  parameter int LIMIT = 200000,
  parameter int STEP  = 1,
  parameter int DWELL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [CBITS-1:0] wr_limit,
  input  logic             wr_mode,
  output logic [CBITS-1:0] vol,
  output logic             sig,
  output logic             dir,
  output logic             done
);

  localparam logic [7:0]       DWELL_C = 8'(DWELL);
  localparam logic [CBITS-1:0] LIMIT_C = CBITS'(LIMIT);

  state_e           state, state_n;
  mode_e            mode;
  logic [CBITS-1:0] lim, lim_n, vol_n, rise_v, fall_v;
  logic [7:0]       dwell, dwell_n;
  logic             pend, pend_n, done_n, clamp, at_top;

  assign rise_v = CBITS'(sat_add(AW'(vol), AW'(STEP), AW'(lim)));
  assign fall_v = CBITS'(sat_sub(AW'(vol), AW'(STEP)));
  assign at_top = (dwell == DWELL_C);
  // A freshly written limit below the level pulls the channel straight into HOLD.
  assign clamp  = pend && (vol >= lim);
  assign pend_n = we && (wr_limit != '0);
  assign lim_n  = pend_n ? wr_limit : lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RISE;
      vol   <= '0;
      dwell <= '0;
      lim   <= LIMIT_C;
      mode  <= MODE_TRI;
      pend  <= 1'b0;
      sig   <= 1'b0;
      dir   <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      vol   <= vol_n;
      dwell <= dwell_n;
      lim   <= lim_n;
      pend  <= pend_n;
      if (we) mode <= mode_e'(wr_mode);
      sig   <= (vol_n == lim_n);
      dir   <= (state_n == RISE);
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    if (clamp) begin
      state_n = HOLD;
    end else if (en) begin
      case (state)
        RISE:    if (rise_v == lim) state_n = HOLD;
        HOLD:    if (at_top) state_n = (mode == MODE_SAW) ? RISE : FALL;
        FALL:    if (fall_v == '0) state_n = RISE;
        default: state_n = RISE;
      endcase
    end
  end

  always_comb begin
    vol_n   = vol;
    dwell_n = dwell;
    done_n  = 1'b0;
    if (clamp) begin
      vol_n   = lim;
      dwell_n = '0;
    end else if (en) begin
      case (state)
        RISE: begin
          vol_n   = rise_v;
          dwell_n = '0;
        end
        HOLD: begin
          if (at_top) begin
            vol_n  = (mode == MODE_SAW) ? '0 : fall_v;
            done_n = (mode == MODE_SAW);
          end else begin
            dwell_n = dwell + 8'd1;
          end
        end
        FALL: begin
          vol_n  = fall_v;
          done_n = (fall_v == '0);
        end
        default: vol_n = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_store_multi.sv
// NCH independent ramp channels with per-channel config decode and packed outputs.
// Outputs come straight from channel registers; no backpressure, en freezes a channel.
module load_store_multi
  import load_store_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CBITS = 18,
  parameter int LIMIT = 200000,
  parameter int STEP  = 1,
  parameter int DWELL = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NCH-1:0]                       en,
  input  logic                                 cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [CBITS-1:0]                     cfg_limit,
  input  logic                                 cfg_mode,
  output logic [NCH*CBITS-1:0]                 vol_o,
  output logic [NCH-1:0]                       sig,
  output logic [NCH-1:0]                       dir_o,
  output logic [NCH-1:0]                       done,
  output logic                                 any_sig
);

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic we_i;
    assign we_i = cfg_we && (32'(cfg_ch) == i);

    load_store_channel #(
      .CBITS(CBITS),
      .LIMIT(LIMIT),
      .STEP (STEP),
      .DWELL(DWELL)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .we      (we_i),
      .wr_limit(cfg_limit),
      .wr_mode (cfg_mode),
      .vol     (vol_o[i*CBITS +: CBITS]),
      .sig     (sig[i]),
      .dir     (dir_o[i]),
      .done    (done[i])
    );
  end

  assign any_sig = |sig;

endmodule

// File: tb/tb_load_store_multi.sv
// Two configurations (STEP=1/DWELL=2 x4 channels, STEP=3/DWELL=0 x3 channels) against a
// queue-based scoreboard fed by a behavioural ramp model, plus directed trace checks.
module tb_load_store_multi;

  localparam int UP = 0, TOP = 1, DOWN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_a;
  logic        we_a;
  logic [1:0]  ch_a;
  logic [7:0]  lim_a;
  logic        mode_a;
  logic [31:0] vol_a;
  logic [3:0]  sig_a, dir_a, done_a;
  logic        any_a;
  logic [2:0]  en_b;
  logic        we_b;
  logic [1:0]  ch_b;
  logic [7:0]  lim_b;
  logic        mode_b;
  logic [23:0] vol_b;
  logic [2:0]  sig_b, dir_b, done_b;
  logic        any_b;

  always #5 clk = ~clk;

  load_store_multi #(.NCH(4), .CBITS(8), .LIMIT(10), .STEP(1), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .cfg_we(we_a), .cfg_ch(ch_a), .cfg_limit(lim_a),
    .cfg_mode(mode_a), .vol_o(vol_a), .sig(sig_a), .dir_o(dir_a), .done(done_a), .any_sig(any_a));

  load_store_multi #(.NCH(3), .CBITS(8), .LIMIT(10), .STEP(3), .DWELL(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .cfg_we(we_b), .cfg_ch(ch_b), .cfg_limit(lim_b),
    .cfg_mode(mode_b), .vol_o(vol_b), .sig(sig_b), .dir_o(dir_b), .done(done_b), .any_sig(any_b));

  typedef struct {
    int vol; int lim; bit saw; int ph; int hold; bit pend; bit done;
  } ch_t;

  typedef struct packed {
    logic [31:0] vol; logic [3:0] sig; logic [3:0] dir; logic [3:0] done; logic any;
  } exp_t;

  ch_t  ma[4];
  ch_t  mb[3];
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;
  int   trb[8] = '{3, 6, 9, 10, 7, 4, 1, 0};

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Level rules: climb by step capped at the limit, sit at the limit dwell+1 cycles,
  // then descend to 0 (triangle) or drop to 0 (sawtooth); a new limit below the level clamps.
  function automatic ch_t mstep(ch_t c, bit r, bit en, bit we, int wl, bit wm, int step, int dwell);
    ch_t n;
    n = c;
    n.done = 0;
    if (r) begin
      n.vol = 0; n.lim = 10; n.saw = 0; n.ph = UP; n.hold = 0; n.pend = 0;
      return n;
    end
    if (c.pend && c.vol >= c.lim) begin
      n.vol = c.lim; n.ph = TOP; n.hold = 0;
    end else if (en) begin
      if (c.ph == UP) begin
        n.vol = (c.vol + step > c.lim) ? c.lim : c.vol + step;
        if (n.vol == c.lim) begin n.ph = TOP; n.hold = 0; end
      end else if (c.ph == TOP) begin
        if (c.hold == dwell) begin
          if (c.saw) begin n.vol = 0; n.ph = UP; n.done = 1; end
          else begin n.vol = (c.vol > step) ? c.vol - step : 0; n.ph = DOWN; end
        end else n.hold = c.hold + 1;
      end else begin
        n.vol = (c.vol > step) ? c.vol - step : 0;
        if (n.vol == 0) begin n.ph = UP; n.done = 1; end
      end
    end
    n.pend = we && (wl != 0);
    if (n.pend) n.lim = wl;
    if (we) n.saw = wm;
    return n;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      ma[i] = mstep(ma[i], rst, en_a[i], we_a && (int'(ch_a) == i), int'(lim_a), mode_a, 1, 2);
      e.vol[i*8 +: 8] = ma[i].vol[7:0];
      e.sig[i] = (ma[i].vol == ma[i].lim);
      e.dir[i] = (ma[i].ph == UP);
      e.done[i] = ma[i].done;
    end
    e.any = |e.sig;
    qa.push_back(e);
    e = '0;
    for (int i = 0; i < 3; i++) begin
      mb[i] = mstep(mb[i], rst, en_b[i], we_b && (int'(ch_b) == i), int'(lim_b), mode_b, 3, 0);
      e.vol[i*8 +: 8] = mb[i].vol[7:0];
      e.sig[i] = (mb[i].vol == mb[i].lim);
      e.dir[i] = (mb[i].ph == UP);
      e.done[i] = mb[i].done;
    end
    e.any = |e.sig;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_vol", vol_a, ea.vol);
      chk("a_sig", 32'(sig_a), 32'(ea.sig));
      chk("a_dir", 32'(dir_a), 32'(ea.dir));
      chk("a_done", 32'(done_a), 32'(ea.done));
      chk("a_any", 32'(any_a), 32'(ea.any));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_vol", {8'd0, vol_b}, eb.vol);
      chk("b_sig", 32'(sig_b), 32'(eb.sig));
      chk("b_dir", 32'(dir_b), 32'(eb.dir));
      chk("b_done", 32'(done_b), 32'(eb.done));
      chk("b_any", 32'(any_b), 32'(eb.any));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int expv;
    rst = 1; en_a = '0; we_a = 0; ch_a = '0; lim_a = '0; mode_a = 0;
    en_b = '0; we_b = 0; ch_b = '0; lim_b = '0; mode_b = 0;
    tick();
    tick();
    // Frozen cycle: ch2 of A becomes a limit-4 sawtooth, B gets a write to a nonexistent channel.
    rst = 0; we_a = 1; ch_a = 2'd2; lim_a = 8'd4; mode_a = 1;
    we_b = 1; ch_b = 2'd3; lim_b = 8'd2; mode_b = 1;
    tick();
    we_a = 0; we_b = 0; en_a = 4'hf; en_b = 3'h7;
    for (int c = 1; c <= 25; c++) begin
      tick();
      expv = (c <= 10) ? c : (c <= 12) ? 10 : (c <= 22) ? 22 - c : c - 22;
      chk("trace_a_vol", 32'(vol_a[7:0]), 32'(expv));
      chk("trace_a_done", 32'(done_a[0]), (c == 22) ? 32'd1 : 32'd0);
      if (c <= 8) begin
        chk("trace_b_vol", 32'(vol_b[7:0]), 32'(trb[c-1]));
        chk("trace_b_done", 32'(done_b[0]), (c == 8) ? 32'd1 : 32'd0);
      end
      we_a = (c == 5); ch_a = 2'd0; lim_a = 8'd0; mode_a = 0;
    end
    we_a = 0;
    // Shrink ch1's limit while it rises through 8.
    k = 0;
    while (!(ma[1].ph == UP && ma[1].vol == 8) && k < 100) begin tick(); k++; end
    chk("ch1_at8", 32'(vol_a[15:8]), 32'd8);
    we_a = 1; ch_a = 2'd1; lim_a = 8'd5; mode_a = 0;
    tick();
    we_a = 0;
    tick();
    chk("ch1_clamp_vol", 32'(vol_a[15:8]), 32'd5);
    chk("ch1_clamp_sig", 32'(sig_a[1]), 32'd1);
    repeat (3) tick();
    chk("ch1_falls", 32'(vol_a[15:8]), 32'd4);
    // Freeze ch3 at 6 on the way up.
    k = 0;
    while (!(ma[3].ph == UP && ma[3].vol == 6) && k < 100) begin tick(); k++; end
    chk("ch3_at6", 32'(vol_a[31:24]), 32'd6);
    en_a[3] = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("ch3_frozen_vol", 32'(vol_a[31:24]), 32'd6);
      chk("ch3_frozen_done", 32'(done_a[3]), 32'd0);
    end
    en_a[3] = 1;
    tick();
    chk("ch3_resume", 32'(vol_a[31:24]), 32'd7);
    // Reset while ch0 dwells at its limit.
    k = 0;
    while (ma[0].ph != TOP && k < 100) begin tick(); k++; end
    chk("ch0_hold_sig", 32'(sig_a[0]), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_vol_a", vol_a, 32'd0);
    chk("rst_vol_b", {8'd0, vol_b}, 32'd0);
    for (int n = 0; n < 2500; n++) begin
      rst    = ($urandom_range(0, 299) == 0);
      en_a   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hf;
      en_b   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'h7;
      we_a   = ($urandom_range(0, 9) == 0);
      we_b   = ($urandom_range(0, 9) == 0);
      ch_a   = 2'($urandom);
      ch_b   = 2'($urandom);
      lim_a  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      lim_b  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      mode_a = 1'($urandom);
      mode_b = 1'($urandom);
      tick();
    end
    rst = 0; we_a = 0; we_b = 0;
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
